spi_req_scheduler: RTL and testbench

- Shares one SPI master register port (CONFIG/TX/CMD write strobes, STATE/RX read strobes, 8-bit PWDATA/PRDATA) between four requesters. Requester i always targets slave select SSi.
- Per granted request, drives the full master sequence: configure, load TX, start, poll busy, read RX. Returns the RX byte with a done pulse.
- Sits between local requester logic and the SPI master, in place of direct strobe driving.

---
 rtl/spi_req_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_spi_req_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_req_scheduler.sv
// Arbitrates four requesters onto one SPI master register port and runs the
// configure / load / start / poll / read sequence for each granted request.
module spi_req_scheduler #(
    parameter logic [7:0]  MODE_MAP = 8'b11100100,
    parameter logic [3:0]  CLK_DIV  = 4'd2,
    parameter logic [15:0] TIMEOUT  = 16'd1000
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic [3:0]  i_req,
    input  logic [31:0] i_tx_data,
    output logic [3:0]  o_grant,
    output logic [3:0]  o_done,
    output logic        o_err,
    output logic [7:0]  o_rx_data,
    output logic        o_busy,
    output logic        o_WR0,
    output logic        o_WR1,
    output logic        o_WR2,
    output logic        o_WR3,
    output logic        o_DR0,
    output logic        o_DR1,
    output logic        o_DR2,
    output logic        o_DR3,
    output logic [7:0]  o_PWDATA,
    input  logic [7:0]  i_PRDATA
);

    localparam int unsigned N_REQ = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] POLL_LAST = TIMEOUT - CNT_W'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_TX, S_CMD, S_SETTLE, S_POLL, S_RXRD, S_ABORT, S_DONE
    } state_t;

    state_t            r_state;
    logic [1:0]        r_rr_ptr;
    logic [1:0]        r_sel;
    logic [DW-1:0]     r_tx_byte;
    logic [CNT_W-1:0]  r_poll_cnt;
    logic [N_REQ-1:0]  r_grant;
    logic [N_REQ-1:0]  r_done;
    logic              r_err;
    logic [DW-1:0]     r_rx_data;
    logic              r_busy;
    logic              r_wr0;
    logic              r_wr1;
    logic              r_wr3;
    logic              r_dr0;
    logic              r_dr1;
    logic [DW-1:0]     r_pwdata;

    logic              w_found;
    logic [1:0]        w_sel;
    logic [1:0]        w_idx;
    logic [DW-1:0]     w_cfg_byte;
    logic [DW-1:0]     w_tx_byte;

    // Round-robin pick: first requesting index at or after the pointer.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_rr_ptr;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = r_rr_ptr + 2'(k);
            if (!w_found && i_req[w_idx]) begin
                w_sel   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign w_cfg_byte = {CLK_DIV, w_sel, MODE_MAP[{w_sel, 1'b0} +: 2]};
    assign w_tx_byte  = i_tx_data[{w_sel, 3'b000} +: DW];

    // Outputs are loaded on the edge that enters the state they belong to.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_sel      <= '0;
            r_tx_byte  <= '0;
            r_poll_cnt <= '0;
            r_grant    <= '0;
            r_done     <= '0;
            r_err      <= 1'b0;
            r_rx_data  <= '0;
            r_busy     <= 1'b0;
            r_wr0      <= 1'b0;
            r_wr1      <= 1'b0;
            r_wr3      <= 1'b0;
            r_dr0      <= 1'b0;
            r_dr1      <= 1'b0;
            r_pwdata   <= '0;
        end else begin
            r_wr0  <= 1'b0;
            r_wr1  <= 1'b0;
            r_wr3  <= 1'b0;
            r_dr0  <= 1'b0;
            r_dr1  <= 1'b0;
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant   <= N_REQ'(1) << w_sel;
                        r_sel     <= w_sel;
                        r_tx_byte <= w_tx_byte;
                        r_pwdata  <= w_cfg_byte;
                        r_wr0     <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_CFG;
                    end
                end
                S_CFG: begin
                    r_wr1    <= 1'b1;
                    r_pwdata <= r_tx_byte;
                    r_state  <= S_TX;
                end
                S_TX: begin
                    r_wr3    <= 1'b1;
                    r_pwdata <= 8'h01;
                    r_state  <= S_CMD;
                end
                S_CMD: begin
                    r_poll_cnt <= '0;
                    r_state    <= S_SETTLE;
                end
                S_SETTLE: begin
                    r_dr0   <= 1'b1;
                    r_state <= S_POLL;
                end
                // Busy bit is valid combinationally while the STATE read strobe is up.
                S_POLL: begin
                    if (!i_PRDATA[0]) begin
                        r_dr1   <= 1'b1;
                        r_state <= S_RXRD;
                    end else if (r_poll_cnt == POLL_LAST) begin
                        r_wr3    <= 1'b1;
                        r_pwdata <= 8'h00;
                        r_state  <= S_ABORT;
                    end else begin
                        r_poll_cnt <= r_poll_cnt + CNT_W'(1);
                        r_state    <= S_SETTLE;
                    end
                end
                S_RXRD: begin
                    r_rx_data <= i_PRDATA;
                    r_done    <= r_grant;
                    r_err     <= 1'b0;
                    r_state   <= S_DONE;
                end
                S_ABORT: begin
                    r_rx_data <= 8'h00;
                    r_done    <= r_grant;
                    r_err     <= 1'b1;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    r_rr_ptr <= r_sel + 2'd1;
                    r_grant  <= '0;
                    r_err    <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_grant <= '0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_grant   = r_grant;
    assign o_done    = r_done;
    assign o_err     = r_err;
    assign o_rx_data = r_rx_data;
    assign o_busy    = r_busy;
    assign o_WR0     = r_wr0;
    assign o_WR1     = r_wr1;
    assign o_WR2     = 1'b0;
    assign o_WR3     = r_wr3;
    assign o_DR0     = r_dr0;
    assign o_DR1     = r_dr1;
    assign o_DR2     = 1'b0;
    assign o_DR3     = 1'b0;
    assign o_PWDATA  = r_pwdata;

endmodule

// File: tb/tb_spi_req_scheduler.sv
// Directed bench for spi_req_scheduler with a behavioural SPI master status/RX model.
module tb_spi_req_scheduler;

    logic        PCLK;
    logic        PRESETn;
    logic [3:0]  i_req;
    logic [31:0] i_tx_data;
    logic [3:0]  o_grant, o_done;
    logic        o_err, o_busy;
    logic [7:0]  o_rx_data, o_PWDATA, prdata_a;
    logic        o_WR0, o_WR1, o_WR2, o_WR3, o_DR0, o_DR1, o_DR2, o_DR3;

    logic [3:0]  b_req;
    logic [3:0]  b_grant, b_done;
    logic        b_err, b_busy;
    logic [7:0]  b_rx_data, b_PWDATA, prdata_b;
    logic        b_WR0, b_WR1, b_WR2, b_WR3, b_DR0, b_DR1, b_DR2, b_DR3;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   busy_left = 0;
    bit   pend_poll = 1'b0;
    logic [7:0] rx_val = 8'h00;

    int   multi_bad = 0;
    int   dr0_n, dr1_n, wr3_n, gap_bad, last_dr0;
    logic [7:0] cfg_b, tx_b, cmd_b;
    int   dr0_bn, wr3_bn;
    logic [7:0] cmd_bb;

    assign prdata_a = o_DR1 ? rx_val : (o_DR0 ? {7'd0, busy_left != 0} : 8'h00);
    assign prdata_b = 8'h01;

    spi_req_scheduler u_dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .i_req(i_req), .i_tx_data(i_tx_data),
        .o_grant(o_grant), .o_done(o_done), .o_err(o_err), .o_rx_data(o_rx_data),
        .o_busy(o_busy), .o_WR0(o_WR0), .o_WR1(o_WR1), .o_WR2(o_WR2), .o_WR3(o_WR3),
        .o_DR0(o_DR0), .o_DR1(o_DR1), .o_DR2(o_DR2), .o_DR3(o_DR3),
        .o_PWDATA(o_PWDATA), .i_PRDATA(prdata_a)
    );

    spi_req_scheduler #(.TIMEOUT(16'd4)) u_to (
        .PCLK(PCLK), .PRESETn(PRESETn), .i_req(b_req), .i_tx_data(i_tx_data),
        .o_grant(b_grant), .o_done(b_done), .o_err(b_err), .o_rx_data(b_rx_data),
        .o_busy(b_busy), .o_WR0(b_WR0), .o_WR1(b_WR1), .o_WR2(b_WR2), .o_WR3(b_WR3),
        .o_DR0(b_DR0), .o_DR1(b_DR1), .o_DR2(b_DR2), .o_DR3(b_DR3),
        .o_PWDATA(b_PWDATA), .i_PRDATA(prdata_b)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        dr0_n = 0; dr1_n = 0; wr3_n = 0; gap_bad = 0; last_dr0 = -1;
        cfg_b = 8'hXX; tx_b = 8'hXX; cmd_b = 8'hXX;
        dr0_bn = 0; wr3_bn = 0; cmd_bb = 8'hXX;
    endtask

    // One clock: retire a busy poll after the edge, then sample at the falling edge.
    task automatic tick();
        int ns;
        @(posedge PCLK);
        #1;
        if (pend_poll) begin
            if (busy_left > 0) busy_left--;
            pend_poll = 1'b0;
        end
        @(negedge PCLK);
        cyc++;
        ns = int'(o_WR0) + int'(o_WR1) + int'(o_WR2) + int'(o_WR3)
           + int'(o_DR0) + int'(o_DR1) + int'(o_DR2) + int'(o_DR3);
        if (ns > 1) multi_bad++;
        ns = int'(b_WR0) + int'(b_WR1) + int'(b_WR2) + int'(b_WR3)
           + int'(b_DR0) + int'(b_DR1) + int'(b_DR2) + int'(b_DR3);
        if (ns > 1) multi_bad++;
        if (o_WR0) cfg_b = o_PWDATA;
        if (o_WR1) tx_b  = o_PWDATA;
        if (o_WR3) begin cmd_b = o_PWDATA; wr3_n++; end
        if (o_DR1) dr1_n++;
        if (o_DR0) begin
            dr0_n++;
            if (last_dr0 >= 0 && cyc - last_dr0 != 2) gap_bad++;
            last_dr0  = cyc;
            pend_poll = 1'b1;
        end
        if (b_DR0) dr0_bn++;
        if (b_WR3) begin cmd_bb = b_PWDATA; wr3_bn++; end
    endtask

    task automatic wait_done(input bit use_b, output int n);
        n = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if ((use_b ? b_done : o_done) != 4'd0) begin
                n = i + 1;
                break;
            end
        end
        if (n < 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL done_wait: no done pulse within 40 cycles");
        end
    endtask

    initial begin
        int n;
        logic [7:0] exp_cfg [4];
        logic [3:0] exp_gnt [5];
        exp_cfg = '{8'h20, 8'h25, 8'h2A, 8'h2F};
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        PRESETn   = 1'b0;
        i_req     = 4'd0;
        b_req     = 4'd0;
        i_tx_data = 32'h0;
        clear_stats();
        tick();
        tick();
        check("rst_ctrl", {o_grant, o_done, o_err, o_busy}, 32'h0);
        check("rst_strb", {o_WR0, o_WR1, o_WR2, o_WR3, o_DR0, o_DR1, o_DR2, o_DR3}, 32'h0);
        check("rst_data", {o_PWDATA, o_rx_data}, 32'h0);
        PRESETn = 1'b1;
        tick();

        // Single request, slave idle at the first poll.
        clear_stats();
        i_tx_data = 32'h000000A5;
        rx_val    = 8'hF0;
        busy_left = 0;
        i_req     = 4'b0001;
        tick();
        check("cfg_cycle", {o_WR0, o_busy, o_grant}, {26'd0, 1'b1, 1'b1, 4'b0001});
        wait_done(1'b0, n);
        check("single_lat", 32'(n + 1), 32'd7);
        check("single_cfg", cfg_b, 8'h20);
        check("single_tx", tx_b, 8'hA5);
        check("single_cmd", cmd_b, 8'h01);
        check("single_polls", {dr0_n[15:0], dr1_n[15:0]}, {16'd1, 16'd1});
        check("single_done", {o_done, o_err, o_rx_data}, {4'b0001, 1'b0, 8'hF0});
        i_req = 4'b0000;
        tick();
        check("rx_hold", {o_done, o_rx_data}, {4'b0000, 8'hF0});

        // Each requester in turn uses its own slave select and mode.
        i_tx_data = 32'h44332211;
        for (int i = 0; i < 4; i++) begin
            clear_stats();
            rx_val = 8'hF0 + 8'(i);
            i_req  = 4'b0001 << i;
            wait_done(1'b0, n);
            check($sformatf("mode_cfg%0d", i), cfg_b, exp_cfg[i]);
            check($sformatf("mode_tx%0d", i), tx_b, i_tx_data[8*i +: 8]);
            check($sformatf("mode_rx%0d", i), {o_done, o_rx_data}, {4'b0001 << i, rx_val});
            i_req = 4'b0000;
            tick();
        end

        // All four held: strict rotation starting from pointer 0.
        i_req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_done(1'b0, n);
            check($sformatf("rr_grant%0d", i), o_grant, exp_gnt[i]);
        end
        i_req = 4'b0000;
        tick();

        // Move the pointer to 2, then 0 and 1 request together.
        i_req = 4'b0010;
        wait_done(1'b0, n);
        i_req = 4'b0000;
        tick();
        i_req = 4'b0011;
        wait_done(1'b0, n);
        check("rr_wrap", o_grant, 4'b0001);
        i_req = 4'b0000;
        tick();

        // Slave busy for five polls.
        clear_stats();
        rx_val    = 8'h5C;
        busy_left = 5;
        i_req     = 4'b0100;
        wait_done(1'b0, n);
        check("busy_polls", dr0_n, 6);
        check("busy_gap", gap_bad, 0);
        check("busy_lat", 32'(n), 32'd17);
        check("busy_done", {o_done, o_err, o_rx_data}, {4'b0100, 1'b0, 8'h5C});
        i_req = 4'b0000;
        tick();

        // Timeout on the TIMEOUT=4 instance with busy stuck high.
        clear_stats();
        b_req = 4'b0001;
        wait_done(1'b1, n);
        check("to_polls", dr0_bn, 4);
        check("to_stop", {cmd_bb, wr3_bn[7:0]}, {8'h00, 8'd2});
        check("to_done", {b_done, b_err, b_rx_data, b_busy}, {4'b0001, 1'b1, 8'h00, 1'b1});
        b_req = 4'b0000;
        tick();
        check("to_clear", {b_done, b_err, b_busy}, 32'h0);

        // Reset while polling, request still pending afterwards.
        clear_stats();
        busy_left = 100;
        rx_val    = 8'h3D;
        i_req     = 4'b0001;
        n = 0;
        for (int i = 0; i < 20 && !o_DR0; i++) tick();
        check("rst_reach_poll", o_DR0, 1'b1);
        PRESETn = 1'b0;
        #1;
        check("rst_async", {o_grant, o_done, o_err, o_busy, o_DR0, o_WR0, o_WR1, o_WR3, o_DR1, o_PWDATA},
              32'h0);
        tick();
        tick();
        check("rst_no_done", o_done, 4'b0000);
        busy_left = 0;
        PRESETn   = 1'b1;
        tick();
        check("rst_restart", {o_WR0, o_grant, o_PWDATA}, {19'd0, 1'b1, 4'b0001, 8'h20});
        wait_done(1'b0, n);
        check("rst_done", {o_done, o_rx_data}, {4'b0001, 8'h3D});
        i_req = 4'b0000;
        tick();

        check("one_strobe", multi_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
